clip_controller: RTL and testbench
==================================

CLIP_CONTROLLER -- requirements
Module: clip_controller

Interface
REQ-001 Parameter CLIP_DEPTH, default 4096, samples per clip; SHALL be a power of two >= 2.
REQ-002 Parameter OFS_W, default $clog2(CLIP_DEPTH), clip-local offset width.
REQ-003 clock  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 q  in  5  synchronized controls {reset_btn, record_btn, play_btn, clipselectionwrite, clipselectionread}, bit 4 to bit 0.
REQ-006 sample_tick  in  1  one-cycle audio-rate strobe.
REQ-007 mem_we  out  1  one-cycle clip-memory write strobe.
REQ-008 mem_re  out  1  one-cycle clip-memory read strobe.
REQ-009 mem_addr  out  OFS_W+2  {active_clip, offset}.
REQ-010 state  out  2  IDLE=0, RECORD=1, PLAY=2.
REQ-011 active_clip  out  2  clip latched at operation start.
REQ-012 clip_valid  out  4  per-clip flag: recorded content present.
REQ-013 done  out  1  one-cycle pulse when an operation ends.

Function
REQ-014 Clip select SHALL be {q[0], q[1]} (clipselectionread = MSB); sampled only on the cycle a record/play rise is accepted.
REQ-015 Rise on record_btn/play_btn SHALL be q bit AND NOT its registered previous value; previous-value registers reset to 0.
REQ-016 q[4] high SHALL act as synchronous soft clear: next edge state, offset, lengths, clip_valid, strobes, done return to reset values; highest priority.
REQ-017 IDLE: record rise -> RECORD, offset=0, active_clip latched; record rise wins over simultaneous play rise.
REQ-018 IDLE: play rise with clip_valid[sel]=1 -> PLAY, offset=0, active_clip latched; with clip_valid[sel]=0 -> remain IDLE, no done.
REQ-019 sample_tick coincident with the accepted rise SHALL NOT generate an access; first access on the next tick.
REQ-020 RECORD: each sample_tick -> mem_we=1 on the following cycle with mem_addr={active_clip, offset}; offset increments after the write.
REQ-021 RECORD: write at offset=CLIP_DEPTH-1 -> length[clip]=CLIP_DEPTH, clip_valid[clip]=1, done=1, IDLE, all on the same cycle as that mem_we.
REQ-022 RECORD: record rise -> IDLE, done=1, length[clip]=offset; clip_valid[clip]=(offset!=0); no further writes. Play rise ignored.
REQ-023 PLAY: each sample_tick -> mem_re=1 on the following cycle with mem_addr={active_clip, offset}; offset increments.
REQ-024 PLAY: read at offset=length[clip]-1 -> done=1, IDLE on the same cycle as that mem_re.
REQ-025 PLAY: play rise -> IDLE, done=1, no further reads. Record rise ignored.
REQ-026 mem_we and mem_re SHALL never be high together; mem_addr holds its last value when both low.
REQ-027 Re-recording a clip SHALL overwrite its length; clip_valid[clip] cleared on record start.

Reset
REQ-028 On reset: state=IDLE, offset=0, active_clip=0, clip_valid=0, all lengths=0, mem_we=mem_re=done=0, mem_addr=0.
REQ-029 Reset asserted mid-RECORD or mid-PLAY SHALL abort with no done pulse and no partial clip_valid update.

Structure
REQ-030 Shared package clip_pkg SHALL hold the state enum (IDLE/RECORD/PLAY) and q bit-index constants.
REQ-031 One sub-module, edge_detect, SHALL provide the registered rise detection for record_btn and play_btn.

Verification (bench CLIP_DEPTH=8, sample_tick every 4 cycles)
REQ-032 Reset held, then release -> all outputs 0, state=0.
REQ-033 q={0,1,0,0,1} rise, 8 ticks -> 8 mem_we pulses, addr 0x10..0x17, done with 8th, clip_valid=4'b0100.
REQ-034 Record clip 1 ({q0,q1}=01), record rise after 3 ticks -> addrs 0x08..0x0A, done, length 3; play clip 1 -> 3 mem_re at 0x08..0x0A, done.
REQ-035 Play rise on clip 3 with clip_valid[3]=0 -> state stays 0, no mem_re, no done.
REQ-036 Record and play rise same cycle in IDLE -> state=1; q[4] pulse mid-record -> next edge state=0, clip_valid=0, no done.
REQ-037 Async reset mid-PLAY at offset 2 -> outputs clear immediately, no done, clip_valid=0.

Source files
------------

// File: rtl/clip_pkg.sv
// Shared definitions for the clip record/playback controller:
// FSM state encoding and the bit positions of the synchronized control bus.
package clip_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  localparam int Q_RESET  = 4;
  localparam int Q_RECORD = 3;
  localparam int Q_PLAY   = 2;
  localparam int Q_SEL_WR = 1;
  localparam int Q_SEL_RD = 0;

endpackage

// File: rtl/clip_controller_edge_detect.sv
// Registered rising-edge detector: rise is high for the cycle in which a
// bit is 1 and was 0 at the previous clock edge.
module edge_detect #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] sig,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_q;
  logic [W-1:0] prev_d;

  always_comb begin
    prev_d = sig;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = sig & ~prev_q;

endmodule

// File: rtl/clip_controller.sv
// Four-slot clip recorder/player: turns button rises and an audio-rate tick
// into one-cycle clip-memory write/read strobes with a {clip, offset} address.
module clip_controller
  import clip_pkg::*;
#(
  parameter int CLIP_DEPTH = 4096,
  parameter int OFS_W      = $clog2(CLIP_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       q,
  input  logic             sample_tick,
  output logic             mem_we,
  output logic             mem_re,
  output logic [OFS_W+1:0] mem_addr,
  output logic [1:0]       state,
  output logic [1:0]       active_clip,
  output logic [3:0]       clip_valid,
  output logic             done
);

  localparam logic [OFS_W:0] FULL_LEN = (OFS_W+1)'(CLIP_DEPTH);

  state_t           state_q, state_d;
  logic [OFS_W-1:0] offset_q, offset_d;
  logic [1:0]       clip_q, clip_d;
  logic [3:0]       valid_q, valid_d;
  logic [OFS_W:0]   len_q [4];
  logic [OFS_W:0]   len_d [4];
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic [OFS_W+1:0] addr_q, addr_d;
  logic             done_q, done_d;

  logic [1:0] rise;
  logic       rec_rise;
  logic       play_rise;
  logic [1:0] sel;

  edge_detect #(.W(2)) u_edge (
    .clock (clock),
    .reset (reset),
    .sig   ({q[Q_RECORD], q[Q_PLAY]}),
    .rise  (rise)
  );

  assign rec_rise  = rise[1];
  assign play_rise = rise[0];
  // clipselectionread is the MSB of the clip number
  assign sel       = {q[Q_SEL_RD], q[Q_SEL_WR]};

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    clip_d   = clip_q;
    valid_d  = valid_q;
    len_d    = len_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    addr_d   = addr_q;
    done_d   = 1'b0;

    if (q[Q_RESET]) begin
      state_d  = IDLE;
      offset_d = '0;
      valid_d  = '0;
      for (int i = 0; i < 4; i++) begin
        len_d[i] = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (rec_rise) begin
            state_d      = RECORD;
            offset_d     = '0;
            clip_d       = sel;
            valid_d[sel] = 1'b0;
          end else if (play_rise && valid_q[sel]) begin
            state_d  = PLAY;
            offset_d = '0;
            clip_d   = sel;
          end
        end
        RECORD: begin
          // A stop request beats a coincident tick, so no write follows it
          if (rec_rise) begin
            state_d         = IDLE;
            done_d          = 1'b1;
            len_d[clip_q]   = {1'b0, offset_q};
            valid_d[clip_q] = (offset_q != '0);
          end else if (sample_tick) begin
            we_d     = 1'b1;
            addr_d   = {clip_q, offset_q};
            offset_d = offset_q + 1'b1;
            if (offset_q == '1) begin
              state_d         = IDLE;
              done_d          = 1'b1;
              len_d[clip_q]   = FULL_LEN;
              valid_d[clip_q] = 1'b1;
            end
          end
        end
        PLAY: begin
          if (play_rise) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (sample_tick) begin
            re_d     = 1'b1;
            addr_d   = {clip_q, offset_q};
            offset_d = offset_q + 1'b1;
            if ({1'b0, offset_q} + (OFS_W+1)'(1) == len_q[clip_q]) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      offset_q <= '0;
      clip_q   <= '0;
      valid_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      addr_q   <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        len_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      clip_q   <= clip_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      re_q     <= re_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      for (int i = 0; i < 4; i++) begin
        len_q[i] <= len_d[i];
      end
    end
  end

  assign mem_we      = we_q;
  assign mem_re      = re_q;
  assign mem_addr    = addr_q;
  assign state       = state_q;
  assign active_clip = clip_q;
  assign clip_valid  = valid_q;
  assign done        = done_q;

endmodule

// File: tb/tb_clip_controller.sv
// Directed bench for clip_controller with an 8-sample clip and a sample tick
// every fourth cycle; one line per transaction plus a closing summary.
module tb_clip_controller;

  localparam int DEPTH = 8;
  localparam int AW    = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    q;
  logic          sample_tick;
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [1:0]    state;
  logic [1:0]    active_clip;
  logic [3:0]    clip_valid;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;
  int we_cnt, re_cnt, done_cnt, both_cnt, done_we_idx, done_re_idx;
  logic [AW-1:0] we_addrs[$];
  logic [AW-1:0] re_addrs[$];

  clip_controller #(.CLIP_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .q           (q),
    .sample_tick (sample_tick),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_addr    (mem_addr),
    .state       (state),
    .active_clip (active_clip),
    .clip_valid  (clip_valid),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic clear_counts();
    we_cnt = 0; re_cnt = 0; done_cnt = 0; both_cnt = 0;
    done_we_idx = -1; done_re_idx = -1;
    we_addrs.delete();
    re_addrs.delete();
  endtask

  // Drive inputs on the falling edge, observe outputs just after the rising edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      sample_tick = (tick_cnt == 3);
      tick_cnt    = (tick_cnt + 1) % 4;
      @(posedge clock);
      #1;
      if (mem_we) begin we_cnt++; we_addrs.push_back(mem_addr); end
      if (mem_re) begin re_cnt++; re_addrs.push_back(mem_addr); end
      if (mem_we && mem_re) both_cnt++;
      if (done) begin done_cnt++; done_we_idx = we_cnt; done_re_idx = re_cnt; end
    end
  endtask

  task automatic wait_we(input string tag, input int target, input int budget);
    int k = 0;
    while (we_cnt < target && k < budget) begin run(1); k++; end
    check_eq(tag, we_cnt, target);
  endtask

  task automatic wait_re(input string tag, input int target, input int budget);
    int k = 0;
    while (re_cnt < target && k < budget) begin run(1); k++; end
    check_eq(tag, re_cnt, target);
  endtask

  task automatic check_addrs(input string tag, input logic is_we, input int base, input int n);
    logic [31:0] got;
    for (int i = 0; i < n; i++) begin
      if (is_we) got = (i < we_addrs.size()) ? 32'(we_addrs[i]) : 32'hFFFF_FFFF;
      else       got = (i < re_addrs.size()) ? 32'(re_addrs[i]) : 32'hFFFF_FFFF;
      check_eq($sformatf("%s_addr%0d", tag, i), got, 32'(base + i));
    end
  endtask

  initial begin
    reset = 1'b1; q = 5'b0; sample_tick = 1'b0;
    clear_counts();
    run(3);
    @(negedge clock);
    reset = 1'b0;
    run(1);
    check_eq("rst_state", state, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_re", mem_re, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_clip", active_clip, 0);
    check_eq("rst_valid", clip_valid, 0);
    check_eq("rst_done", done, 0);

    // Full-length record into clip 2
    clear_counts();
    q = 5'b01001; run(1);
    check_eq("rec2_state", state, 1);
    check_eq("rec2_clip", active_clip, 2);
    q = 5'b00001; run(45);
    check_eq("rec2_we_cnt", we_cnt, 8);
    check_addrs("rec2", 1'b1, 'h10, 8);
    check_eq("rec2_done_cnt", done_cnt, 1);
    check_eq("rec2_done_idx", done_we_idx, 8);
    check_eq("rec2_valid", clip_valid, 4'b0100);
    check_eq("rec2_idle", state, 0);

    // Short record into clip 1, stopped after three samples
    clear_counts();
    q = 5'b01010; run(1);
    q = 5'b00010;
    wait_we("rec1_progress", 3, 40);
    q = 5'b01010; run(1);
    q = 5'b00010; run(12);
    check_eq("rec1_we_cnt", we_cnt, 3);
    check_addrs("rec1", 1'b1, 'h08, 3);
    check_eq("rec1_done_cnt", done_cnt, 1);
    check_eq("rec1_valid", clip_valid, 4'b0110);
    check_eq("rec1_idle", state, 0);

    // Play back clip 1: three reads then done
    clear_counts();
    q = 5'b00110; run(1);
    check_eq("play1_state", state, 2);
    q = 5'b00010; run(30);
    check_eq("play1_re_cnt", re_cnt, 3);
    check_addrs("play1", 1'b0, 'h08, 3);
    check_eq("play1_done_cnt", done_cnt, 1);
    check_eq("play1_done_idx", done_re_idx, 3);
    check_eq("play1_we_cnt", we_cnt, 0);
    check_eq("play1_idle", state, 0);

    // Play of an empty clip is refused
    clear_counts();
    q = 5'b00111; run(1);
    check_eq("play3_state", state, 0);
    q = 5'b00011; run(12);
    check_eq("play3_re_cnt", re_cnt, 0);
    check_eq("play3_done_cnt", done_cnt, 0);

    // Simultaneous rises pick record; soft clear aborts it
    q = 5'b00000; run(1);
    clear_counts();
    q = 5'b01100; run(1);
    check_eq("both_state", state, 1);
    q = 5'b00000; run(10);
    clear_counts();
    q = 5'b10000; run(1);
    check_eq("soft_state", state, 0);
    check_eq("soft_valid", clip_valid, 0);
    check_eq("soft_we", mem_we, 0);
    q = 5'b00000; run(10);
    check_eq("soft_done_cnt", done_cnt, 0);
    check_eq("soft_we_cnt", we_cnt, 0);

    // Record four samples to clip 0, play two, then async reset
    clear_counts();
    q = 5'b01000; run(1);
    q = 5'b00000;
    wait_we("rec0_progress", 4, 40);
    q = 5'b01000; run(1);
    q = 5'b00000; run(2);
    check_eq("rec0_valid", clip_valid, 4'b0001);
    clear_counts();
    q = 5'b00100; run(1);
    q = 5'b00000;
    wait_re("play0_progress", 2, 40);
    check_eq("play0_state", state, 2);
    reset = 1'b1;
    #1;
    check_eq("arst_state", state, 0);
    check_eq("arst_re", mem_re, 0);
    check_eq("arst_addr", mem_addr, 0);
    check_eq("arst_valid", clip_valid, 0);
    check_eq("arst_done", done, 0);
    run(2);
    @(negedge clock);
    reset = 1'b0;
    clear_counts();
    run(20);
    check_eq("arst_done_cnt", done_cnt, 0);
    check_eq("arst_re_cnt", re_cnt, 0);
    check_eq("arst_state_after", state, 0);

    check_eq("we_re_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
